// File: rtl/h3_decode_pipe_15_11.sv
// Two-stage, flow-controlled Hamming(15,11) single-error-correcting decode pipe
// with a saturating corrected-word counter and sticky flag for slow control.

module h3_correct_15_11 (
    input  logic [14:0] code_i,
    output logic [14:0] code_o,
    output logic        sec_o
);
    logic [3:0]  syn;
    logic [14:0] flip;

    // Syndrome is the XOR of the 1-based positions of all set bits
    always_comb begin
        syn = 4'd0;
        for (int unsigned p = 1; p <= 15; p++) begin
            if (code_i[p-1]) syn = syn ^ 4'(p);
        end
    end

    assign sec_o  = (syn != 4'd0);
    assign flip   = sec_o ? (15'(1) << (syn - 4'd1)) : 15'd0;
    assign code_o = code_i ^ flip;
endmodule

module h3_decode_pipe_15_11 #(
    parameter int unsigned N     = 15,
    parameter int unsigned K     = 11,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [K-1:0]     out_data_o,
    output logic             out_sec_o,
    input  logic             clear_cnt_i,
    output logic [CNT_W-1:0] sec_count_o,
    output logic             sec_sticky_o
);
    logic             s1_valid_q, s2_valid_q, s2_sec_q;
    logic [N-1:0]     s1_data_q;
    logic [K-1:0]     s2_data_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    logic             s2_free, s1_adv, in_fire, out_fire;
    logic [N-1:0]     corr;
    logic             corr_sec;
    logic [K-1:0]     info;

    h3_correct_15_11 u_correct (
        .code_i (s1_data_q),
        .code_o (corr),
        .sec_o  (corr_sec)
    );

    // Drop parity positions 1,2,4,8; keep positions 3,5,6,7,9..15
    assign info = {corr[14], corr[13], corr[12], corr[11], corr[10], corr[9],
                   corr[8], corr[6], corr[5], corr[4], corr[2]};

    assign s2_free    = !s2_valid_q || out_ready_i;
    assign s1_adv     = s1_valid_q && s2_free;
    assign in_ready_o = !s1_valid_q || s2_free;
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = s2_valid_q && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sec_q   <= 1'b0;
        end else begin
            s1_valid_q <= in_fire || (s1_valid_q && !s1_adv);
            if (in_fire) s1_data_q <= in_data_i;
            if (s1_adv) begin
                s2_valid_q <= 1'b1;
                s2_data_q  <= info;
                s2_sec_q   <= corr_sec;
            end else if (out_fire) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle SEC delivery; counter saturates
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clear_cnt_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (out_fire && s2_sec_q) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign out_data_o   = s2_data_q;
    assign out_sec_o    = s2_sec_q;
    assign sec_count_o  = cnt_q;
    assign sec_sticky_o = sticky_q;
endmodule

// File: tb/tb_h3_decode_pipe_15_11.sv
// Directed bench for the Hamming(15,11) decode pipe; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.

module tb_h3_decode_pipe_15_11;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [14:0] in_data;
    logic        out_ready;
    logic        clear_cnt;

    logic        in_ready,  out_valid,  out_sec,  sticky;
    logic [10:0] out_data;
    logic [15:0] count;
    logic        in_ready_s, out_valid_s, out_sec_s, sticky_s;
    logic [10:0] out_data_s;
    logic [1:0]  count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    h3_decode_pipe_15_11 dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_sec_o(out_sec),
        .clear_cnt_i(clear_cnt), .sec_count_o(count), .sec_sticky_o(sticky)
    );

    h3_decode_pipe_15_11 #(.CNT_W(2)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_s), .in_data_i(in_data),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready),
        .out_data_o(out_data_s), .out_sec_o(out_sec_s),
        .clear_cnt_i(clear_cnt), .sec_count_o(count_s), .sec_sticky_o(sticky_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word, no backpressure: valid two edges after the input handshake
    task automatic send_word(input string tag, input logic [14:0] w,
                             input logic [10:0] ed, input logic es);
        @(negedge clk);
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(ed));
        chk({tag, "_sec"},   32'(out_sec),   32'(es));
        @(negedge clk);
    endtask

    logic [14:0] vec_w [8] = '{15'h0007, 15'h0017, 15'h7FFE, 15'h7FFF,
                               15'h408B, 15'h418B, 15'h7FFB, 15'h4000};
    logic [10:0] vec_d [8] = '{11'h001, 11'h001, 11'h7FF, 11'h7FF,
                               11'h400, 11'h400, 11'h7FF, 11'h000};
    logic        vec_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int idx, got, occ;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_cnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_sticky",    32'(sticky),    32'd0);
        rst_n = 1'b1;

        // Clean, single-error and parity-position-error words
        send_word("t1", 15'h0007, 11'h001, 1'b0);
        chk("t1_count", 32'(count), 32'd0);
        send_word("t2", 15'h0017, 11'h001, 1'b1);
        chk("t2_count",  32'(count),  32'd1);
        chk("t2_sticky", 32'(sticky), 32'd1);
        send_word("t3a", 15'h7FFE, 11'h7FF, 1'b1);
        send_word("t3b", 15'h7FFF, 11'h7FF, 1'b0);
        chk("t3_count", 32'(count), 32'd2);

        // Random backpressure stream, scoreboarded in order
        idx = 0; got = 0; occ = 0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (idx < 8);
            in_data   = (idx < 8) ? vec_w[idx] : 15'h0;
            #1;
            chk("t4_in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                chk("t4_data", 32'(out_data), 32'(vec_d[got]));
                chk("t4_sec",  32'(out_sec),  32'(vec_s[got]));
                got++; occ--;
            end
            if (in_valid && in_ready) begin
                idx++; occ++;
            end
        end
        chk("t4_delivered", 32'(got), 32'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t4_drained",  32'(out_valid), 32'd0);
        chk("t4_count",    32'(count),     32'd7);
        chk("t4_count_s",  32'(count_s),   32'd3);

        // Plain clear
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        chk("clr_count",   32'(count),   32'd0);
        chk("clr_sticky",  32'(sticky),  32'd0);
        chk("clr_count_s", 32'(count_s), 32'd0);

        // Saturation on the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 15'h0017; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_count_s",  32'(count_s),  32'd3);
        chk("t5_sticky_s", 32'(sticky_s), 32'd1);
        chk("t5_count",    32'(count),    32'd5);

        // Clear coinciding with a SEC handshake
        @(negedge clk);
        in_valid = 1'b1; in_data = 15'h0017;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_hs_valid", 32'(out_valid), 32'd1);
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        chk("t5_clr_count",    32'(count),    32'd0);
        chk("t5_clr_sticky",   32'(sticky),   32'd0);
        chk("t5_clr_count_s",  32'(count_s),  32'd0);
        chk("t5_clr_sticky_s", 32'(sticky_s), 32'd0);

        // Reset with both stages full
        send_word("t6pre", 15'h0017, 11'h001, 1'b1);
        chk("t6pre_count", 32'(count), 32'd1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 15'h0007;
        @(negedge clk);
        in_data = 15'h7FFF;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t6_full_in_ready",  32'(in_ready),  32'd0);
        chk("t6_full_out_valid", 32'(out_valid), 32'd1);
        chk("t6_hold_data",      32'(out_data),  32'h001);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready",  32'(in_ready),  32'd1);
        chk("t6_rst_count",     32'(count),     32'd0);
        chk("t6_rst_sticky",    32'(sticky),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word("t6post", 15'h408B, 11'h400, 1'b0);
        chk("t6post_empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
